// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and defaults for the RC4 decrypt pipeline
package rc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_SI_A = 4'd1,
    RD_SI_W = 4'd2,
    RD_SJ_A = 4'd3,
    RD_SJ_W = 4'd4,
    WR_SI   = 4'd5,
    WR_SJ   = 4'd6,
    RD_F_A  = 4'd7,
    RD_F_W  = 4'd8,
    WR_DEC  = 4'd9,
    DONE    = 4'd10
  } prga_state_t;

  // Message length shared with the ROM/RAM wrappers.
  localparam int DEFAULT_MSG_LEN = 32;

endpackage

// File: rtl/rc4_prga.sv
// rtl/rc4_prga.sv - RC4 PRGA keystream generator and message decrypt stage
module rc4_prga
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = DEFAULT_MSG_LEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       finished,
  output logic [7:0]                 s_address,
  output logic [7:0]                 s_data,
  output logic                       s_wren,
  input  logic [7:0]                 s_q,
  output logic [$clog2(MSG_LEN)-1:0] rom_address,
  input  logic [7:0]                 rom_q,
  output logic [$clog2(MSG_LEN)-1:0] dec_address,
  output logic [7:0]                 dec_data,
  output logic                       dec_wren
);

  localparam int KW = $clog2(MSG_LEN);
  localparam logic [KW-1:0] K_LAST = KW'(MSG_LEN - 1);

  prga_state_t   state;
  byte_t         i, j, si, sj, f, enc;
  logic [KW-1:0] k;

  assign finished = (state == DONE);
  assign dec_data = f ^ enc;

  // Outputs are registered on the edge entering the state that uses them,
  // so they are stable for that whole state and hold afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      si          <= '0;
      sj          <= '0;
      f           <= '0;
      enc         <= '0;
      s_address   <= '0;
      s_data      <= '0;
      s_wren      <= 1'b0;
      rom_address <= '0;
      dec_address <= '0;
      dec_wren    <= 1'b0;
    end else begin
      s_wren   <= 1'b0;
      dec_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            i         <= 8'd1;
            j         <= '0;
            k         <= '0;
            s_address <= 8'd1;
            state     <= RD_SI_A;
          end
        end
        RD_SI_A: state <= RD_SI_W;
        RD_SI_W: begin
          si        <= s_q;
          j         <= j + s_q;
          s_address <= j + s_q;
          state     <= RD_SJ_A;
        end
        RD_SJ_A: state <= RD_SJ_W;
        RD_SJ_W: begin
          sj        <= s_q;
          s_address <= i;
          s_data    <= s_q;
          s_wren    <= 1'b1;
          state     <= WR_SI;
        end
        WR_SI: begin
          s_address <= j;
          s_data    <= si;
          s_wren    <= 1'b1;
          state     <= WR_SJ;
        end
        WR_SJ: begin
          s_address   <= si + sj;
          rom_address <= k;
          state       <= RD_F_A;
        end
        RD_F_A: state <= RD_F_W;
        RD_F_W: begin
          f           <= s_q;
          enc         <= rom_q;
          dec_address <= k;
          dec_wren    <= 1'b1;
          state       <= WR_DEC;
        end
        WR_DEC: begin
          if (k == K_LAST) begin
            state <= DONE;
          end else begin
            i         <= i + 8'd1;
            k         <= k + KW'(1);
            s_address <= i + 8'd1;
            state     <= RD_SI_A;
          end
        end
        DONE: begin
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga.sv
// tb/tb_rc4_prga.sv - randomized self-checking bench for rc4_prga against a software RC4 model
module tb_rc4_prga;
  import rc4_pkg::*;

  localparam int N  = 32;
  localparam int NW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, start_w;

  logic       finished, s_wren, dec_wren;
  logic [7:0] s_address, s_data, s_q, rom_q, dec_data;
  logic [4:0] rom_address, dec_address;

  logic       w_finished, w_s_wren, w_dec_wren;
  logic [7:0] w_s_address, w_s_data, w_s_q, w_rom_q, w_dec_data;
  logic [7:0] w_rom_address, w_dec_address;

  byte_t s_mem[256], rom_mem[256], dec_mem[256];
  byte_t ws_mem[256], wrom_mem[256], wdec_mem[256];
  byte_t m_s[256], m_rom[256], m_dec[256];

  int s_pulses = 0, dec_pulses = 0, wdec_pulses = 0;
  int n_cmp = 0, n_bad = 0;

  rc4_prga #(.MSG_LEN(N)) dut (
    .clk(clk), .reset(reset), .start(start), .finished(finished),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .rom_address(rom_address), .rom_q(rom_q),
    .dec_address(dec_address), .dec_data(dec_data), .dec_wren(dec_wren)
  );

  rc4_prga #(.MSG_LEN(NW)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .finished(w_finished),
    .s_address(w_s_address), .s_data(w_s_data), .s_wren(w_s_wren), .s_q(w_s_q),
    .rom_address(w_rom_address), .rom_q(w_rom_q),
    .dec_address(w_dec_address), .dec_data(w_dec_data), .dec_wren(w_dec_wren)
  );

  // Synchronous-read memories: q reflects the address presented on the previous edge.
  always @(posedge clk) begin
    s_q   <= s_mem[s_address];
    rom_q <= rom_mem[{3'b000, rom_address}];
    if (s_wren) begin
      s_mem[s_address] = s_data;
      s_pulses <= s_pulses + 1;
    end
    if (dec_wren) begin
      dec_mem[{3'b000, dec_address}] = dec_data;
      dec_pulses <= dec_pulses + 1;
    end
    w_s_q   <= ws_mem[w_s_address];
    w_rom_q <= wrom_mem[w_rom_address];
    if (w_s_wren) ws_mem[w_s_address] = w_s_data;
    if (w_dec_wren) begin
      wdec_mem[w_dec_address] = w_dec_data;
      wdec_pulses <= wdec_pulses + 1;
    end
  end

  // Textbook RC4 PRGA over m_s, XORed with m_rom.
  task automatic model_prga(input int n);
    int ii, jj;
    byte_t t;
    ii = 0;
    jj = 0;
    for (int kk = 0; kk < n; kk++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(m_s[ii])) % 256;
      t = m_s[ii];
      m_s[ii] = m_s[jj];
      m_s[jj] = t;
      m_dec[kk] = m_s[(int'(m_s[ii]) + int'(m_s[jj])) % 256] ^ m_rom[kk];
    end
  endtask

  task automatic prep_model_narrow();
    for (int x = 0; x < 256; x++) begin
      m_s[x]   = s_mem[x];
      m_rom[x] = rom_mem[x];
    end
    model_prga(N);
  endtask

  task automatic run_narrow(output int cycles);
    @(negedge clk);
    start = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (finished !== 1'b1 && cycles < 5000);
  endtask

  task automatic stop_narrow();
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    start_w = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (finished !== 1'b0) begin n_bad++; $display("FAIL reset_finished: got %b want 0", finished); end
    n_cmp++; if (s_wren !== 1'b0) begin n_bad++; $display("FAIL reset_s_wren: got %b want 0", s_wren); end
    n_cmp++; if (dec_wren !== 1'b0) begin n_bad++; $display("FAIL reset_dec_wren: got %b want 0", dec_wren); end
    n_cmp++; if (s_address !== 8'h00 || s_data !== 8'h00) begin n_bad++; $display("FAIL reset_s_bus: got %h/%h want 00/00", s_address, s_data); end
    n_cmp++; if (rom_address !== 5'd0 || dec_address !== 5'd0 || dec_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_addr: got rom %h dec %h data %h want 0", rom_address, dec_address, dec_data);
    end
    n_cmp++; if (w_finished !== 1'b0 || w_s_wren !== 1'b0 || w_dec_wren !== 1'b0) begin
      n_bad++; $display("FAIL reset_wide: got %b%b%b want 000", w_finished, w_s_wren, w_dec_wren);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_identity();
    int cyc;
    byte_t exp3[3];
    exp3[0] = 8'h02; exp3[1] = 8'h05; exp3[2] = 8'h07;
    for (int x = 0; x < 256; x++) begin
      s_mem[x] = byte_t'(x);
      rom_mem[x] = 8'h00;
      dec_mem[x] = 8'hxx;
    end
    prep_model_narrow();
    run_narrow(cyc);
    for (int x = 0; x < 3; x++) begin
      n_cmp++; if (dec_mem[x] !== exp3[x]) begin n_bad++; $display("FAIL ident_dec%0d: got %h want %h", x, dec_mem[x], exp3[x]); end
    end
    for (int x = 0; x < N; x++) begin
      n_cmp++; if (dec_mem[x] !== m_dec[x]) begin n_bad++; $display("FAIL ident_model_dec[%0d]: got %h want %h", x, dec_mem[x], m_dec[x]); end
    end
    for (int x = 0; x < 256; x++) begin
      n_cmp++; if (s_mem[x] !== m_s[x]) begin n_bad++; $display("FAIL ident_s[%0d]: got %h want %h", x, s_mem[x], m_s[x]); end
    end
    stop_narrow();
  endtask

  task automatic test_rom_ff_and_handshake();
    int cyc, s0, d0, t;
    bit held;
    byte_t exp3[3];
    exp3[0] = 8'hFD; exp3[1] = 8'hFA; exp3[2] = 8'hF8;
    for (int x = 0; x < 256; x++) begin
      s_mem[x] = byte_t'(x);
      rom_mem[x] = (x < 3) ? 8'hFF : byte_t'($urandom);
    end
    prep_model_narrow();
    s0 = s_pulses;
    d0 = dec_pulses;
    run_narrow(cyc);
    n_cmp++; if (cyc !== 9 * N + 1) begin n_bad++; $display("FAIL ff_latency: got %0d cycles want %0d", cyc, 9 * N + 1); end
    for (int x = 0; x < 3; x++) begin
      n_cmp++; if (dec_mem[x] !== exp3[x]) begin n_bad++; $display("FAIL ff_dec%0d: got %h want %h", x, dec_mem[x], exp3[x]); end
    end
    for (int x = 0; x < N; x++) begin
      n_cmp++; if (dec_mem[x] !== m_dec[x]) begin n_bad++; $display("FAIL ff_model_dec[%0d]: got %h want %h", x, dec_mem[x], m_dec[x]); end
    end
    n_cmp++; if (dec_pulses - d0 !== N) begin n_bad++; $display("FAIL ff_dec_pulses: got %0d want %0d", dec_pulses - d0, N); end
    n_cmp++; if (s_pulses - s0 !== 2 * N) begin n_bad++; $display("FAIL ff_s_pulses: got %0d want %0d", s_pulses - s0, 2 * N); end

    // start held past finished: stay in DONE, no writes
    s0 = s_pulses;
    d0 = dec_pulses;
    held = 1'b1;
    for (t = 0; t < 100; t++) begin
      @(posedge clk);
      #1;
      if (finished !== 1'b1) held = 1'b0;
    end
    n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL hs_hold: got finished drop want held 1"); end
    n_cmp++; if (s_pulses != s0 || dec_pulses != d0) begin
      n_bad++; $display("FAIL hs_no_writes: got %0d/%0d writes want 0/0", s_pulses - s0, dec_pulses - d0);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (finished !== 1'b0) begin n_bad++; $display("FAIL hs_drop: got finished %b want 0", finished); end

    // Second run on the permuted S must restart from i=1, j=0, k=0
    for (int x = 0; x < 256; x++) rom_mem[x] = byte_t'($urandom);
    prep_model_narrow();
    run_narrow(cyc);
    n_cmp++; if (cyc !== 9 * N + 1) begin n_bad++; $display("FAIL hs_rerun_latency: got %0d want %0d", cyc, 9 * N + 1); end
    for (int x = 0; x < N; x++) begin
      n_cmp++; if (dec_mem[x] !== m_dec[x]) begin n_bad++; $display("FAIL hs_rerun_dec[%0d]: got %h want %h", x, dec_mem[x], m_dec[x]); end
    end
    stop_narrow();
  endtask

  task automatic test_reset_mid_run();
    int cyc, s0, d0, t;
    for (int x = 0; x < 256; x++) begin
      s_mem[x] = byte_t'(x);
      rom_mem[x] = byte_t'($urandom);
    end
    s0 = s_pulses;
    d0 = dec_pulses;
    @(negedge clk);
    start = 1'b1;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!(s_wren === 1'b1 && s_pulses - s0 == 9) && t < 1000);
    n_cmp++; if (t >= 1000 || dec_pulses - d0 != 4) begin
      n_bad++; $display("FAIL rst_reach_wr_sj: got t=%0d dec=%0d want byte 5 WR_SJ with 4 dec writes", t, dec_pulses - d0);
    end
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (s_wren !== 1'b0 || dec_wren !== 1'b0 || finished !== 1'b0) begin
      n_bad++; $display("FAIL rst_abort: got s_wren %b dec_wren %b finished %b want 000", s_wren, dec_wren, finished);
    end
    @(negedge clk);
    reset = 1'b1;
    prep_model_narrow();
    d0 = dec_pulses;
    run_narrow(cyc);
    n_cmp++; if (cyc !== 9 * N + 1) begin n_bad++; $display("FAIL rst_rerun_latency: got %0d want %0d", cyc, 9 * N + 1); end
    n_cmp++; if (dec_pulses - d0 !== N) begin n_bad++; $display("FAIL rst_rerun_pulses: got %0d want %0d", dec_pulses - d0, N); end
    for (int x = 0; x < N; x++) begin
      n_cmp++; if (dec_mem[x] !== m_dec[x]) begin n_bad++; $display("FAIL rst_rerun_dec[%0d]: got %h want %h", x, dec_mem[x], m_dec[x]); end
    end
    stop_narrow();
  endtask

  task automatic test_random_perm();
    int cyc, r, pos;
    byte_t t;
    for (int iter = 0; iter < 3; iter++) begin
      for (int x = 0; x < 256; x++) s_mem[x] = byte_t'(x);
      for (int x = 255; x > 0; x--) begin
        r = int'($urandom_range(x, 0));
        t = s_mem[x]; s_mem[x] = s_mem[r]; s_mem[r] = t;
      end
      if (iter == 0) begin
        // S[1]==1 makes j==i==1 on the first byte
        pos = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] == 8'd1) pos = x;
        t = s_mem[1]; s_mem[1] = s_mem[pos]; s_mem[pos] = t;
      end
      for (int x = 0; x < 256; x++) rom_mem[x] = byte_t'($urandom);
      prep_model_narrow();
      run_narrow(cyc);
      n_cmp++; if (cyc !== 9 * N + 1) begin n_bad++; $display("FAIL rand%0d_latency: got %0d want %0d", iter, cyc, 9 * N + 1); end
      for (int x = 0; x < N; x++) begin
        n_cmp++; if (dec_mem[x] !== m_dec[x]) begin n_bad++; $display("FAIL rand%0d_dec[%0d]: got %h want %h", iter, x, dec_mem[x], m_dec[x]); end
      end
      for (int x = 0; x < 256; x++) begin
        n_cmp++; if (s_mem[x] !== m_s[x]) begin n_bad++; $display("FAIL rand%0d_s[%0d]: got %h want %h", iter, x, s_mem[x], m_s[x]); end
      end
      stop_narrow();
    end
  endtask

  task automatic test_wrap_256();
    int cyc, d0;
    for (int x = 0; x < 256; x++) begin
      ws_mem[x] = byte_t'(x);
      wrom_mem[x] = byte_t'($urandom);
      m_s[x] = ws_mem[x];
      m_rom[x] = wrom_mem[x];
    end
    model_prga(NW);
    d0 = wdec_pulses;
    @(negedge clk);
    start_w = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (w_finished !== 1'b1 && cyc < 10000);
    n_cmp++; if (cyc !== 9 * NW + 1) begin n_bad++; $display("FAIL wrap_latency: got %0d want %0d", cyc, 9 * NW + 1); end
    n_cmp++; if (wdec_pulses - d0 !== NW) begin n_bad++; $display("FAIL wrap_pulses: got %0d want %0d", wdec_pulses - d0, NW); end
    for (int x = 0; x < NW; x++) begin
      n_cmp++; if (wdec_mem[x] !== m_dec[x]) begin n_bad++; $display("FAIL wrap_dec[%0d]: got %h want %h", x, wdec_mem[x], m_dec[x]); end
    end
    for (int x = 0; x < 256; x++) begin
      n_cmp++; if (ws_mem[x] !== m_s[x]) begin n_bad++; $display("FAIL wrap_s[%0d]: got %h want %h", x, ws_mem[x], m_s[x]); end
    end
    @(negedge clk);
    start_w = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      s_mem[x] = 8'h00; rom_mem[x] = 8'h00; dec_mem[x] = 8'h00;
      ws_mem[x] = 8'h00; wrom_mem[x] = 8'h00; wdec_mem[x] = 8'h00;
    end
    test_reset();
    test_identity();
    test_rom_ff_and_handshake();
    test_reset_mid_run();
    test_random_perm();
    test_wrap_256();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rc4_prga.md
Name: rc4_prga

Overview:
- Keystream generation and decrypt stage of the RC4 pipeline. It reads back the permuted S array left by the init/shuffle controller, performs the RC4 PRGA swap per byte, XORs each keystream byte with the encrypted-message ROM, and writes the plaintext to the decrypted-message RAM.
- Uses the same start/finished handshake as the S-array controller, so the top-level sequencer runs it as the stage after shuffle.

Parameters:
- MSG_LEN, 32, number of message bytes processed per run (1..256).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (reset==0 resets on rising clk)
- start  input  1  level request; run begins when sampled high in IDLE
- finished  output  1  high while in DONE
- s_address  output  8  S RAM address
- s_data  output  8  S RAM write data
- s_wren  output  1  S RAM write enable
- s_q  input  8  S RAM read data
- rom_address  output  $clog2(MSG_LEN)  encrypted ROM address (= k)
- rom_q  input  8  encrypted ROM data
- dec_address  output  $clog2(MSG_LEN)  decrypted RAM address
- dec_data  output  8  decrypted RAM write data
- dec_wren  output  1  decrypted RAM write enable

Behaviour:
- Reset (reset==0 at rising edge): state=IDLE; i, j, k, si, sj, f all cleared to 0. Outputs: finished=0, s_wren=0, dec_wren=0, all addresses and data 0.
- Reset mid-run aborts immediately. No further writes are issued; partially written RAMs are not restored.
- Registers: i, j, si, sj, f are 8 bits; k is $clog2(MSG_LEN) bits. All byte arithmetic is mod 256 with natural 8-bit wrap. i wraps 255 to 0.
- RAM timing (S RAM and ROM): the address is held for 2 cycles; q is sampled at the end of the second cycle (*_A then *_W state).
- Write enables are asserted for exactly one cycle, with address and data valid in that same cycle.
- FSM, one state per cycle:
  - IDLE: if start, set i<=1, j<=0, k<=0 and go to RD_SI_A.
  - RD_SI_A / RD_SI_W: s_address=i. In RD_SI_W: si<=s_q, j<=j+s_q.
  - RD_SJ_A / RD_SJ_W: s_address=j (already updated). In RD_SJ_W: sj<=s_q.
  - WR_SI: s_address=i, s_data=sj, s_wren=1.
  - WR_SJ: s_address=j, s_data=si, s_wren=1.
  - RD_F_A / RD_F_W: s_address=si+sj; rom_address=k in both cycles. In RD_F_W: f<=s_q, enc<=rom_q.
  - WR_DEC: dec_address=k, dec_data=f^enc, dec_wren=1.
    - If k==MSG_LEN-1, go to DONE.
    - Otherwise i<=i+1, k<=k+1, go to RD_SI_A.
  - DONE: finished=1. Stay while start==1; go to IDLE when start==0. finished drops in the IDLE cycle.
- Latency: 9 cycles per byte. finished rises 9*MSG_LEN+1 cycles after the edge on which start is sampled in IDLE.
- i==j: both swap writes target the same address with equal data, which is correct; no special case.
- start deasserted mid-run: ignored; the run completes.
- start still high on return to IDLE: impossible, because DONE waits for start low.
- s_address, rom_address and dec_address hold their last value outside the states that drive them; only the enables matter.

Decomposition:
- rc4_pkg holds:
  - the prga_state_t enum (IDLE, RD_SI_A, RD_SI_W, RD_SJ_A, RD_SJ_W, WR_SI, WR_SJ, RD_F_A, RD_F_W, WR_DEC, DONE)
  - the byte_t typedef (logic [7:0])
  - the default MSG_LEN constant, shared with the ROM/RAM wrappers.
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Identity S (S[x]=x, no KSA), ROM = 32 bytes of 0x00, MSG_LEN=32, start held high -> dec[0..2] = 0x02, 0x05, 0x07. After the run, S[2]=0x03, S[3]=0x05, S[5]=0x02.
- Same S with ROM[0..2] = 0xFF -> dec[0..2] = 0xFD, 0xFA, 0xF8. finished rises exactly 289 cycles after start is sampled. Exactly 32 dec_wren pulses and 64 s_wren pulses.
- Handshake: keep start high 100 cycles past finished -> finished stays 1 and no writes occur. Drop start -> finished=0 the next cycle. Re-raise start -> a second run begins from i=1, j=0, k=0.
- Reset (reset=0) asserted during WR_SJ of byte 5 -> next cycle all enables are 0 and finished=0. A subsequent start performs a full 32-byte run.
- Random permuted S preloaded plus a golden software RC4 PRGA model -> all 32 dec bytes and the final S array match the model. Include a case forcing i==j at byte 0.
- Wrap: MSG_LEN=256 with identity S -> i wraps to 0 at byte 255 with no stall. finished rises after 2305 cycles.
